// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM states,
// the NOP encoding used to reset IF/ID, and the default PC width.
package fetch_pkg;

  localparam int unsigned PC_W_DEF  = 9;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction word that arrives while
// the pipeline is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o <= 1'b0;
      data_o  <= NOP_INSTR;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, single-outstanding memory
// handshake, IF/ID register with stall skid, redirect and halt handling.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | one cycle after reset, no request
// REQ   | request at pc, waiting for grant
// WAIT  | granted, waiting for the response
// HOLD  | response parked in the skid buffer while stalled
// DRAIN | redirect/halt with a response in flight; discard it
// HALT  | fetch stopped until reset
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            pc_sel_i,
  input  logic [31:0]     br_pc_i,
  input  logic            halt_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [PC_W-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
  output logic            flush_o,
  output logic            halted_o
);

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic            halt_pend, halt_pend_nxt;
  logic            if_load, if_from_skid, if_kill, flush_nxt;
  logic            skid_load, skid_clr, skid_valid;
  logic [31:0]     skid_data;
  logic            redirect, outstanding;
  logic [PC_W-1:0] target_pc;
  logic            unused_br;

  assign target_pc   = {br_pc_i[PC_W-1:2], 2'b00};
  assign unused_br   = ^{br_pc_i[31:PC_W], br_pc_i[1:0]};
  assign imem_addr_o = pc;
  assign halted_o    = (state == S_HALT);

  // A halt already being drained is final; later redirects must not revive fetch.
  assign redirect = pc_sel_i && !halt_i && !(state == S_DRAIN && halt_pend);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    halt_pend_nxt = halt_pend;
    imem_req_o    = 1'b0;
    if_load       = 1'b0;
    if_from_skid  = 1'b0;
    if_kill       = 1'b0;
    flush_nxt     = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    outstanding   = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        imem_req_o = !stall_i;
        if (imem_req_o && imem_gnt_i) state_nxt = S_WAIT;
        outstanding = imem_req_o && imem_gnt_i;
      end
      S_WAIT: begin
        outstanding = !imem_rvalid_i;
        if (imem_rvalid_i) begin
          if (!stall_i) begin
            if_load   = 1'b1;
            pc_nxt    = pc + PC_W'(4);
            state_nxt = S_REQ;
          end else begin
            skid_load = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          if_load      = skid_valid;
          if_from_skid = 1'b1;
          skid_clr     = 1'b1;
          pc_nxt       = pc + PC_W'(4);
          state_nxt    = S_REQ;
        end
      end
      S_DRAIN: begin
        outstanding = !imem_rvalid_i;
        if (imem_rvalid_i) begin
          state_nxt     = halt_pend ? S_HALT : S_REQ;
          halt_pend_nxt = 1'b0;
        end
      end
      S_HALT: ;
      default: state_nxt = S_IDLE;
    endcase

    if (state != S_HALT && (halt_i || redirect)) begin
      flush_nxt = 1'b1;
      if_kill   = 1'b1;
      if_load   = 1'b0;
      skid_load = 1'b0;
      skid_clr  = 1'b1;
      if (halt_i) begin
        halt_pend_nxt = outstanding;
        state_nxt     = outstanding ? S_DRAIN : S_HALT;
      end else begin
        pc_nxt    = target_pc;
        state_nxt = outstanding ? S_DRAIN : S_REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      halt_pend  <= 1'b0;
      flush_o    <= 1'b0;
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_instr_o <= NOP_INSTR;
    end else begin
      pc        <= pc_nxt;
      halt_pend <= halt_pend_nxt;
      flush_o   <= flush_nxt;
      if (if_load) begin
        if_valid_o <= 1'b1;
        if_pc_o    <= pc;
        if_instr_o <= if_from_skid ? skid_data : imem_rdata_i;
      end else if (if_kill || !stall_i) begin
        if_valid_o <= 1'b0;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clr),
    .data_i  (imem_rdata_i),
    .data_o  (skid_data),
    .valid_o (skid_valid)
  );

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 9, width of the program counter and instruction-memory address.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 stall_i  in  1  hazard stall; hold the IF/ID outputs and issue no new request.
REQ-007 pc_sel_i  in  1  redirect request from branch resolution.
REQ-008 br_pc_i  in  32  redirect target.
REQ-009 halt_i  in  1  halt resolved; qualifies pc_sel_i.
REQ-010 imem_req_o  out  1  instruction-fetch request.
REQ-011 imem_addr_o  out  PC_W  fetch byte address.
REQ-012 imem_gnt_i  in  1  request accepted this cycle.
REQ-013 imem_rvalid_i  in  1  response valid; at most one outstanding request.
REQ-014 imem_rdata_i  in  32  instruction word.
REQ-015 if_valid_o  out  1  IF/ID entry valid.
REQ-016 if_pc_o  out  PC_W  PC of the IF/ID instruction.
REQ-017 if_instr_o  out  32  IF/ID instruction.
REQ-018 flush_o  out  1  one-cycle pulse to squash younger pipeline stages.
REQ-019 halted_o  out  1  fetch permanently stopped.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, HOLD, DRAIN, HALT.
REQ-021 IDLE: imem_req_o=0; advance to REQ on the next clock unconditionally.
REQ-022 REQ: imem_req_o=!stall_i and imem_addr_o=pc; when imem_req_o and imem_gnt_i are both high, go to WAIT; otherwise stay in REQ.
REQ-023 WAIT with imem_rvalid_i and !stall_i: load IF/ID with (pc, imem_rdata_i, valid=1); set pc to pc+4 modulo 2^PC_W; go to REQ.
REQ-024 WAIT with imem_rvalid_i and stall_i: capture the response in a one-entry skid register; go to HOLD. pc and IF/ID are unchanged.
REQ-025 HOLD with !stall_i: load IF/ID from the skid register; set pc to pc+4; go to REQ.
REQ-026 When !stall_i and IF/ID is not loaded this cycle, if_valid_o clears to 0 on the next edge. When stall_i is high, all IF/ID outputs hold.
REQ-027 Redirect (pc_sel_i=1, halt_i=0) overrides stall_i:
- pc is set to br_pc_i[PC_W-1:2] with bits [1:0] forced to 00.
- if_valid_o is 0 next cycle, the skid register is cleared, and flush_o=1 for exactly the next cycle.
REQ-028 Redirect state transition: go to DRAIN if a request is outstanding after this edge (state WAIT without rvalid, or REQ with gnt this cycle); otherwise go to REQ.
REQ-029 Redirect in WAIT coincident with imem_rvalid_i: discard the response and go to REQ.
REQ-030 DRAIN: imem_req_o=0; discard the next imem_rvalid_i, then go to REQ.
REQ-031 Halt (halt_i=1, with or without pc_sel_i):
- Same flush actions as a redirect, with pc frozen.
- If a response is outstanding, drain it first; then go to HALT.
REQ-032 HALT: imem_req_o=0, if_valid_o=0, halted_o=1; leave HALT only by reset. All other inputs are ignored.
REQ-033 Priority, highest first: reset, halt, redirect, stall, normal fetch.
REQ-034 Minimum fetch latency: 2 cycles from grant to if_valid_o when memory returns rvalid the cycle after gnt.

Reset
REQ-035 Reset forces asynchronously:
- state=IDLE, pc=RESET_PC.
- if_valid_o=0, if_pc_o=0, if_instr_o=32'h00000013 (NOP).
- flush_o=0, halted_o=0, imem_req_o=0, skid register empty.
REQ-036 Reset asserted mid-transaction abandons the outstanding request; no response is consumed until after IDLE.

Structure
REQ-037 Package fetch_pkg holds the state enum, the NOP constant and the default PC_W.
REQ-038 The skid register is a sub-module named fetch_skid_buf: one entry, load/clear/valid.

Verification
REQ-039 Reset release, memory grants immediately and returns rdata=32'h00500093 one cycle later -> if_valid_o=1, if_pc_o=0, if_instr_o=32'h00500093; next imem_addr_o=4.
REQ-040 stall_i high when the response arrives at pc=8 -> IF/ID holds the old entry; after stall_i drops, if_pc_o=8 with the captured word; next fetch address is 12.
REQ-041 pc_sel_i with br_pc_i=32'h40 while in WAIT, rvalid one cycle later -> that response is discarded; flush_o pulses once; next imem_addr_o=0x40.
REQ-042 halt_i with pc_sel_i in REQ with no grant -> halted_o=1, imem_req_o stays 0 for 20 cycles, if_valid_o=0.
REQ-043 pc=0x1FC (PC_W=9), normal fetch -> next imem_addr_o=0x000 (wrap-around).
